capture_readout_ctrl: RTL and testbench

Sequencer wrapped around logic_analyzer_core and its sample buffer.
- On an arm command it clears and enables the core, then waits for trigger and capture_done.
- It then reads the full circular buffer in time order, oldest sample first, starting PRE_TRIG samples before trigger_index.
- Read samples stream out on a valid/ready byte interface toward the UART streamer.

---
 rtl/capture_readout_ctrl.sv | 152 +++++++++++++++
 tb/tb_capture_readout_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_readout_ctrl.sv
// Capture sequencer around the logic analyzer core: arms the core, waits for
// trigger/completion, then streams the circular buffer out oldest-sample-first.
module capture_readout_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int PRE_TRIG   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  output logic                  core_clear_n,
  output logic                  trigger_enable,
  input  logic                  triggered,
  input  logic                  capture_done,
  input  logic [ADDR_WIDTH-1:0] trigger_index,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [2:0]            state_o,
  output logic                  done_pulse
);

  localparam logic [ADDR_WIDTH:0]   N_CNT   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PRE_OFS = ADDR_WIDTH'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_READ      = 3'd4,
    S_DRAIN     = 3'd5
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   rcnt;
  logic [ADDR_WIDTH-1:0] start_addr;
  entry_t [1:0]          fifo;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic                  inflight, inflight_last;
  logic                  pop, latch_start, flush;
  logic [1:0]            occ_eff;

  assign busy           = (state != S_IDLE);
  assign state_o        = state;
  assign core_clear_n   = (state != S_CLEAR);
  assign trigger_enable = (state == S_WAIT_TRIG) || (state == S_WAIT_DONE);

  assign m_valid    = (count != 2'd0);
  assign m_data     = fifo[rd_ptr].data;
  assign m_last     = m_valid & fifo[rd_ptr].last;
  assign pop        = m_valid & m_ready;
  assign done_pulse = (state == S_DRAIN) & pop & m_last & ~abort;

  // A pop in this cycle frees a slot for the read issued in this cycle.
  assign occ_eff = count + {1'b0, inflight} - {1'b0, pop};
  assign rd_en   = (state == S_READ) && !abort && (rcnt < N_CNT) && (occ_eff < 2'd2);
  assign rd_addr = start_addr + rcnt[ADDR_WIDTH-1:0];

  always_comb begin
    state_nxt   = state;
    latch_start = 1'b0;
    flush       = 1'b0;
    case (state)
      S_IDLE:      if (arm) state_nxt = S_CLEAR;
      S_CLEAR:     state_nxt = S_WAIT_TRIG;
      S_WAIT_TRIG: begin
        if (triggered && capture_done) begin
          state_nxt   = S_READ;
          latch_start = 1'b1;
        end else if (triggered) begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (capture_done) begin
          state_nxt   = S_READ;
          latch_start = 1'b1;
        end
      end
      S_READ:      if (rd_en && (rcnt == N_CNT - 1'b1)) state_nxt = S_DRAIN;
      S_DRAIN:     if (pop && m_last) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && abort) begin
      state_nxt   = S_IDLE;
      latch_start = 1'b0;
      flush       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_addr <= '0;
      rcnt       <= '0;
    end else if (latch_start) begin
      start_addr <= trigger_index - PRE_OFS;
      rcnt       <= '0;
    end else if (rd_en) begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Single outstanding read; its last tag rides along into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= (rcnt == N_CNT - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (inflight) begin
        fifo[wr_ptr] <= '{last: inflight_last, data: rd_data};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Directed/randomized bench for capture_readout_ctrl with a buffer model and
// a time-ordered expected-sample queue.
module tb_capture_readout_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 11;
  localparam int PRE = 1024;
  localparam int N   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, abort, triggered, capture_done, m_ready;
  logic [AW-1:0] trigger_index;
  logic          core_clear_n, trigger_enable, rd_en, m_valid, m_last, busy, done_pulse;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;
  logic [2:0]    state_o;

  capture_readout_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRE_TRIG(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .core_clear_n(core_clear_n), .trigger_enable(trigger_enable),
    .triggered(triggered), .capture_done(capture_done), .trigger_index(trigger_index),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .state_o(state_o), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  // Sample buffer model: one-cycle read latency.
  logic [DW-1:0] bufm [N];
  always @(posedge clk) if (rd_en) rd_data <= bufm[rd_addr];

  int            n_vec = 0, n_err = 0;
  logic          mon_en = 1'b0;
  int            n_rd = 0, n_xf = 0, exp_start = 0, last_addr = 0;
  logic [DW-1:0] exp_q [$];
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stream/read monitor against the expected time-ordered sample sequence.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), (exp_start + n_rd) % N);
        last_addr = int'(rd_addr);
        n_rd++;
      end
      if (m_valid && m_ready) begin
        chk("xfer_overrun", 32'(n_xf < N), 32'd1);
        if (exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        chk("m_last", 32'(m_last), 32'(n_xf == N - 1));
        chk("done_pulse", 32'(done_pulse), 32'(n_xf == N - 1));
        n_xf++;
      end else begin
        chk("done_idle", 32'(done_pulse), 32'd0);
      end
      chk("buffered_le2", 32'((n_rd - n_xf) <= 2), 32'd1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic load_model(input int tidx);
    for (int i = 0; i < N; i++) bufm[i] = 8'($urandom);
    exp_start = (tidx - PRE + N) % N;
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(bufm[(exp_start + k) % N]);
    n_rd = 0; n_xf = 0; prev_stall = 1'b0; mon_en = 1'b1;
  endtask

  task automatic do_arm();
    cyc(); arm = 1'b1; smp();
    cyc(); arm = 1'b0; smp();
    chk("clear_state", 32'(state_o), 32'd1);
    chk("clear_n_low", 32'(core_clear_n), 32'd0);
    chk("clear_te", 32'(trigger_enable), 32'd0);
    chk("clear_busy", 32'(busy), 32'd1);
    cyc(); smp();
    chk("wt_state", 32'(state_o), 32'd2);
    chk("clear_n_one_cycle", 32'(core_clear_n), 32'd1);
    chk("wt_te", 32'(trigger_enable), 32'd1);
  endtask

  task automatic do_capture(input int tidx, input bit simul);
    if (simul) begin
      cyc(); triggered = 1'b1; capture_done = 1'b1; trigger_index = AW'(tidx);
      load_model(tidx); smp();
      cyc(); triggered = 1'b0; capture_done = 1'b0;
    end else begin
      cyc(); triggered = 1'b1; smp();
      cyc(); triggered = 1'b0; smp();
      chk("wd_state", 32'(state_o), 32'd3);
      chk("wd_te", 32'(trigger_enable), 32'd1);
      repeat (4) cyc();
      capture_done = 1'b1; trigger_index = AW'(tidx);
      load_model(tidx); smp();
      cyc(); capture_done = 1'b0;
    end
    smp();
    chk("read_state", 32'(state_o), 32'd4);
    chk("read_te", 32'(trigger_enable), 32'd0);
    chk("first_rd_en", 32'(rd_en), 32'd1);
    chk("first_rd_addr", 32'(rd_addr), 32'((tidx - PRE + N) % N));
  endtask

  task automatic stream(input int duty);
    bit seen = 1'b0;
    for (int c = 0; c < 30000 && !seen; c++) begin
      cyc(); m_ready = ($urandom_range(99) < duty);
      smp();
      if (m_valid && m_ready && m_last) begin
        chk("done_with_last", 32'(done_pulse), 32'd1);
        seen = 1'b1;
      end
    end
    chk("stream_completed", 32'(seen), 32'd1);
    cyc(); smp();
    chk("busy_fall", 32'(busy), 32'd0);
    chk("idle_after", 32'(state_o), 32'd0);
    chk("xfer_total", 32'(n_xf), N);
    chk("rd_total", 32'(n_rd), N);
    mon_en = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; triggered = 1'b0;
    capture_done = 1'b0; m_ready = 1'b0; trigger_index = '0;
    #12;
    chk("rst_clear_n", 32'(core_clear_n), 32'd1);
    chk("rst_te", 32'(trigger_enable), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_done", 32'(done_pulse), 32'd0);
    cyc(); rst_n = 1'b1;

    // Nominal: trigger around cycle 50, trigger_index 1500, m_ready held high.
    do_arm();
    m_ready = 1'b1;
    repeat (44) cyc();
    do_capture(1500, 1'b0);
    cyc(); smp(); chk("valid_lat1", 32'(m_valid), 32'd0);
    cyc(); smp(); chk("valid_lat2", 32'(m_valid), 32'd1);
    stream(100);

    // Wrap-around start address under 30% backpressure.
    do_arm();
    repeat (3) cyc();
    do_capture(100, 1'b0);
    stream(30);
    chk("wrap_last_addr", last_addr, 32'd1123);

    // Trigger and completion in the same cycle.
    do_arm();
    do_capture(int'($urandom_range(N - 1)), 1'b1);
    stream(60);

    // Abort after 10 transfers.
    do_arm();
    do_capture(int'($urandom_range(N - 1)), 1'b0);
    k = 0;
    for (int c = 0; c < 5000 && k < 10; c++) begin
      cyc(); m_ready = 1'b1; smp();
      if (m_valid && m_ready) k++;
    end
    chk("abort_setup_xfers", k, 32'd10);
    cyc(); abort = 1'b1; mon_en = 1'b0; smp();
    cyc(); abort = 1'b0; smp();
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_te", 32'(trigger_enable), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    for (int c = 0; c < 8; c++) begin
      cyc(); smp();
      chk("abort_no_done", 32'(done_pulse), 32'd0);
      chk("abort_no_valid", 32'(m_valid), 32'd0);
    end
    do_arm();
    // Arm during WAIT_DONE ignored; abort beats capture_done.
    cyc(); triggered = 1'b1; smp();
    cyc(); triggered = 1'b0; arm = 1'b1; smp();
    cyc(); arm = 1'b0; smp();
    chk("arm_ignored_state", 32'(state_o), 32'd3);
    chk("arm_ignored_clear_n", 32'(core_clear_n), 32'd1);
    cyc(); abort = 1'b1; capture_done = 1'b1; smp();
    cyc(); abort = 1'b0; capture_done = 1'b0; smp();
    chk("abort_wins_state", 32'(state_o), 32'd0);
    chk("abort_wins_te", 32'(trigger_enable), 32'd0);

    // Asynchronous reset mid-READ, then a clean capture.
    do_arm();
    do_capture(int'($urandom_range(N - 1)), 1'b1);
    for (int c = 0; c < 30; c++) begin
      cyc(); m_ready = 1'($urandom_range(1)); smp();
    end
    mon_en = 1'b0;
    cyc(); #2; rst_n = 1'b0; #1;
    chk("arst_clear_n", 32'(core_clear_n), 32'd1);
    chk("arst_te", 32'(trigger_enable), 32'd0);
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_m_data", 32'(m_data), 32'd0);
    chk("arst_m_last", 32'(m_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_done", 32'(done_pulse), 32'd0);
    cyc(); rst_n = 1'b1;
    do_arm();
    do_capture(int'($urandom_range(N - 1)), 1'b0);
    stream(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
